// File: rtl/maze_comm_pkg.sv
// Shared definitions for the MazeRunner <-> CommMaster serial command link.
package maze_comm_pkg;

  localparam int BAUD_19200_50M = 2604;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
  typedef enum logic       {WAIT_HI, WAIT_LO}         asm_state_t;

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver: RX synchronizer, mid-bit sampling FSM, byte_rdy / frm_err pulses.
module uart_byte_rx
  import maze_comm_pkg::*;
#(
  parameter int BAUD_CYC = BAUD_19200_50M
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic       byte_rdy,
  output logic [7:0] rx_byte,
  output logic       frm_err
);

  localparam int CW = $clog2(BAUD_CYC) + 1;
  // The expiry cycle itself counts as one clock, hence the -1 on both loads.
  localparam logic [CW-1:0] HALF_LD = CW'(BAUD_CYC / 2 - 1);
  localparam logic [CW-1:0] BIT_LD  = CW'(BAUD_CYC - 1);

  logic rx_ff1_q, rx_ff2_q, rx_prev_q;

  rx_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          byte_rdy_q, byte_rdy_d;
  logic          frm_err_q, frm_err_d;
  logic          expired;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ff1_q  <= 1'b1;
      rx_ff2_q  <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_ff1_q  <= RX;
      rx_ff2_q  <= rx_ff1_q;
      rx_prev_q <= rx_ff2_q;
    end
  end

  assign expired = (cnt_q == '0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    byte_rdy_d = 1'b0;
    frm_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_prev_q && !rx_ff2_q) begin
          state_d = START;
          cnt_d   = HALF_LD;
        end
      end
      START: begin
        if (!expired) cnt_d = cnt_q - 1'b1;
        else if (rx_ff2_q) state_d = IDLE;
        else begin
          state_d   = DATA;
          cnt_d     = BIT_LD;
          bit_cnt_d = 4'd0;
        end
      end
      DATA: begin
        if (!expired) cnt_d = cnt_q - 1'b1;
        else begin
          shift_d   = {rx_ff2_q, shift_q[7:1]};
          cnt_d     = BIT_LD;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (!expired) cnt_d = cnt_q - 1'b1;
        else begin
          byte_rdy_d = rx_ff2_q;
          frm_err_d  = !rx_ff2_q;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'h00;
      byte_rdy_q <= 1'b0;
      frm_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      byte_rdy_q <= byte_rdy_d;
      frm_err_q  <= frm_err_d;
    end
  end

  assign byte_rdy = byte_rdy_q;
  assign rx_byte  = shift_q;
  assign frm_err  = frm_err_q;

endmodule

// File: rtl/uart_cmd_rx.sv
// Two-byte (high first) command word assembler on top of uart_byte_rx.
// Define CMD_TIMEOUT_EN to drop a half-received word after TMO_CYC idle clocks.
module uart_cmd_rx
  import maze_comm_pkg::*;
#(
  parameter int BAUD_CYC = BAUD_19200_50M,
  parameter int TMO_CYC  = 131072
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  input  logic        clr_cmd_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  output logic        frm_err
);

  logic       byte_rdy;
  logic [7:0] rx_byte;
  logic       tmo_fire;

  asm_state_t  asm_q, asm_d;
  logic [7:0]  cmd_hi_q, cmd_hi_d;
  logic [15:0] cmd_q, cmd_d;
  logic        cmd_rdy_q, cmd_rdy_d;

  uart_byte_rx #(.BAUD_CYC(BAUD_CYC)) u_byte_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .RX       (RX),
    .byte_rdy (byte_rdy),
    .rx_byte  (rx_byte),
    .frm_err  (frm_err)
  );

`ifdef CMD_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYC + 1);

  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  assign tmo_fire = (asm_q == WAIT_LO) && (tmo_cnt_q == TW'(TMO_CYC - 1));

  // Counter restarts whenever WAIT_LO is (re)entered.
  always_comb begin
    tmo_cnt_d = '0;
    if (asm_q == WAIT_LO && asm_d == WAIT_LO) tmo_cnt_d = tmo_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_cnt_q <= '0;
    else        tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign tmo_fire = 1'b0;
  // TMO_CYC has no effect in this build.
  if (TMO_CYC < 0) begin : g_tmo_unused
  end
`endif

  always_comb begin
    asm_d     = asm_q;
    cmd_hi_d  = cmd_hi_q;
    cmd_d     = cmd_q;
    cmd_rdy_d = cmd_rdy_q;
    if (clr_cmd_rdy) cmd_rdy_d = 1'b0;
    if (frm_err) asm_d = WAIT_HI;
    else if (byte_rdy) begin
      case (asm_q)
        WAIT_HI: begin
          cmd_hi_d  = rx_byte;
          cmd_rdy_d = 1'b0;
          asm_d     = WAIT_LO;
        end
        WAIT_LO: begin
          cmd_d     = {cmd_hi_q, rx_byte};
          cmd_rdy_d = 1'b1;
          asm_d     = WAIT_HI;
        end
        default: asm_d = WAIT_HI;
      endcase
    end else if (tmo_fire) asm_d = WAIT_HI;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q     <= WAIT_HI;
      cmd_hi_q  <= 8'h00;
      cmd_q     <= 16'h0000;
      cmd_rdy_q <= 1'b0;
    end else begin
      asm_q     <= asm_d;
      cmd_hi_q  <= cmd_hi_d;
      cmd_q     <= cmd_d;
      cmd_rdy_q <= cmd_rdy_d;
    end
  end

  assign cmd     = cmd_q;
  assign cmd_rdy = cmd_rdy_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Scoreboard bench for uart_cmd_rx: directed UART frames, monitor pops expected words on cmd_rdy rise.
module tb_uart_cmd_rx;

  localparam int BAUD = 64;
  localparam int TMO  = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic        clr_cmd_rdy = 1'b0;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        frm_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int frm_seen = 0;
  int rise_cyc = -1;
  int start_cyc = 0;
  logic [15:0] exp_q[$];

  uart_cmd_rx #(.BAUD_CYC(BAUD), .TMO_CYC(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RX          (RX),
    .clr_cmd_rdy (clr_cmd_rdy),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .frm_err     (frm_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every cmd_rdy rise must deliver the next expected word.
  initial begin
    logic prev_rdy;
    prev_rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (frm_err) frm_seen++;
        if (cmd_rdy && !prev_rdy) begin
          rise_cyc = cyc;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected: got cmd %h with nothing expected", cmd);
          end else check("sb_cmd", {16'h0, cmd}, {16'h0, exp_q.pop_front()});
        end
      end
      prev_rdy = rst_n ? cmd_rdy : 1'b0;
    end
  end

  // Frame bits: start, 8 data LSB first, stop. nbits < 10 aborts mid-frame.
  task automatic send_byte(input logic [7:0] b, input logic stop, input int nbits);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    @(negedge clk);
    start_cyc = cyc;
    for (int i = 0; i < nbits; i++) begin
      RX = fr[i];
      repeat (BAUD) @(negedge clk);
    end
    RX = 1'b1;
  endtask

  task automatic send_word(input logic [15:0] w);
    send_byte(w[15:8], 1'b1, 10);
    send_byte(w[7:0], 1'b1, 10);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk) clr_cmd_rdy = 1'b1;
    @(negedge clk) clr_cmd_rdy = 1'b0;
  endtask

  initial begin
    int f0;
    idle(3);
    check("rst_cmd", {16'h0, cmd}, 32'h0);
    check("rst_rdy", {31'h0, cmd_rdy}, 32'h0);
    check("rst_frm", {31'h0, frm_err}, 32'h0);
    rst_n = 1'b1;
    idle(5);

    // Word 0001; rdy rises one clock after the mid-stop sample of the low byte
    // (edge + 3 sync/detect + BAUD/2 + 9*BAUD + 1 = 612 clocks).
    exp_q.push_back(16'h0001);
    send_byte(8'h00, 1'b1, 10);
    send_byte(8'h01, 1'b1, 10);
    idle(20);
    check("t1_latency", {31'h0, (rise_cyc - start_cyc >= 608) && (rise_cyc - start_cyc <= 616)}, 32'h1);
    check("t1_rdy", {31'h0, cmd_rdy}, 32'h1);
    check("t1_cmd", {16'h0, cmd}, 32'h0001);
    check("t1_no_frm", frm_seen, 0);

    // Clear, then high-byte accept also clears.
    exp_q.push_back(16'h0003);
    send_word(16'h0003);
    idle(20);
    check("t2_rdy_set", {31'h0, cmd_rdy}, 32'h1);
    pulse_clr();
    idle(1);
    check("t2_rdy_clr", {31'h0, cmd_rdy}, 32'h0);
    exp_q.push_back(16'h0004);
    send_word(16'h0004);
    idle(20);
    check("t2_rdy_set2", {31'h0, cmd_rdy}, 32'h1);
    send_byte(8'hA5, 1'b1, 10);
    idle(20);
    check("t2_hi_clear", {31'h0, cmd_rdy}, 32'h0);
    check("t2_cmd_hold", {16'h0, cmd}, 32'h0004);
    exp_q.push_back(16'hA5C3);
    send_byte(8'hC3, 1'b1, 10);
    idle(20);
    check("t2_rdy", {31'h0, cmd_rdy}, 32'h1);
    check("t2_cmd", {16'h0, cmd}, 32'hA5C3);

    // Bad stop on a high byte.
    pulse_clr();
    f0 = frm_seen;
    send_byte(8'h12, 1'b0, 10);
    idle(BAUD);
    exp_q.push_back(16'h0002);
    send_word(16'h0002);
    idle(20);
    check("t3_frm_cnt", frm_seen - f0, 1);
    check("t3_cmd", {16'h0, cmd}, 32'h0002);

    // Bad stop on a low byte drops the pending high byte.
    f0 = frm_seen;
    send_byte(8'h77, 1'b1, 10);
    send_byte(8'h88, 1'b0, 10);
    idle(BAUD);
    exp_q.push_back(16'h0005);
    send_word(16'h0005);
    idle(20);
    check("t3b_frm_cnt", frm_seen - f0, 1);
    check("t3b_cmd", {16'h0, cmd}, 32'h0005);

    // Clear held across completion: set wins for that cycle.
    @(negedge clk) clr_cmd_rdy = 1'b1;
    rise_cyc = -1;
    exp_q.push_back(16'h0006);
    send_word(16'h0006);
    idle(20);
    check("t4_set_wins", {31'h0, rise_cyc > start_cyc}, 32'h1);
    check("t4_rdy_after", {31'h0, cmd_rdy}, 32'h0);
    check("t4_cmd", {16'h0, cmd}, 32'h0006);
    clr_cmd_rdy = 1'b0;

    // Reset mid low byte.
    send_byte(8'hBE, 1'b1, 10);
    send_byte(8'hEF, 1'b1, 5);
    rst_n = 1'b0;
    idle(2);
    check("t5_rst_cmd", {16'h0, cmd}, 32'h0);
    check("t5_rst_rdy", {31'h0, cmd_rdy}, 32'h0);
    rst_n = 1'b1;
    idle(10);
    exp_q.push_back(16'h0001);
    send_word(16'h0001);
    idle(20);
    check("t5_cmd", {16'h0, cmd}, 32'h0001);

    // Lone byte then long idle.
    send_byte(8'h55, 1'b1, 10);
    idle(1200);
`ifdef CMD_TIMEOUT_EN
    exp_q.push_back(16'h0102);
    send_word(16'h0102);
    idle(20);
    check("t6_cmd", {16'h0, cmd}, 32'h0102);
`else
    exp_q.push_back(16'h5501);
    send_word(16'h0102);
    idle(20);
    check("t6_cmd", {16'h0, cmd}, 32'h5501);
`endif

    check("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
